// File: rtl/keypad_operand_entry_if.sv
// Keypad operand-entry bus: key strobe/code and done handshake in, committed
// operands plus live entry status out. The slave modport is the entry block.
interface keypad_operand_entry_if #(
  parameter int NUM_OPS = 2,
  parameter int DIGITS  = 3,
  parameter int WIDTH   = 10
) ();
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic                       key_valid;
  logic [3:0]                 key_code;
  logic                       done_ack;
  logic [NUM_OPS*WIDTH-1:0]   operands;
  logic [NUM_OPS-1:0]         op_enable;
  logic [WIDTH-1:0]           entry_value;
  logic [CNT_W-1:0]           digit_count;
  logic                       busy;
  logic                       done_valid;

  modport master (
    output key_valid, key_code, done_ack,
    input  operands, op_enable, entry_value, digit_count, busy, done_valid
  );

  modport slave (
    input  key_valid, key_code, done_ack,
    output operands, op_enable, entry_value, digit_count, busy, done_valid
  );
endinterface

// File: rtl/keypad_operand_entry.sv
// Collects NUM_OPS decimal operands from keypad key events (digits, ENTER,
// CLEAR, ABORT) and presents the completed set until the consumer acks it.
module keypad_operand_entry #(
  parameter int NUM_OPS = 2,
  parameter int DIGITS  = 3,
  parameter int WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_operand_entry_if.slave bus
);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ABORT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic                            key_prev_q;
  logic                            armed_q;
  logic [WIDTH-1:0]                acc_q, acc_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_OPS-1:0][WIDTH-1:0]   ops_q, ops_d;
  logic [NUM_OPS-1:0]              op_en_q, op_en_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic             key_ev;
  logic             is_digit;
  logic             do_commit;
  logic [WIDTH-1:0] acc_step;

  // armed_q blocks a key already held when reset releases from counting as a press.
  assign key_ev   = armed_q & bus.key_valid & ~key_prev_q;
  assign is_digit = (bus.key_code <= 4'd9);
  assign acc_step = acc_q * WIDTH'(10) + WIDTH'(bus.key_code);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ops_d     = ops_q;
    do_commit = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (key_ev && is_digit) begin
          ops_d   = '0;
          idx_d   = '0;
          acc_d   = WIDTH'(bus.key_code);
          cnt_d   = CNT_W'(1);
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (key_ev) begin
          if (is_digit) begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            case (bus.key_code)
              KEY_ENTER: do_commit = (cnt_q != '0);
              KEY_CLEAR: begin
                acc_d = '0;
                cnt_d = '0;
              end
              KEY_ABORT: begin
                ops_d   = '0;
                acc_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
              end
              default: ;
            endcase
          end
        end
      end
      S_DONE: begin
        if (bus.done_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A full operand commits in the same update that accepted its last digit.
    if (state_d == S_ENTRY && cnt_d == CNT_W'(DIGITS)) do_commit = 1'b1;

    if (do_commit) begin
      ops_d[idx_d] = acc_d;
      acc_d        = '0;
      cnt_d        = '0;
      if (idx_d == IDX_W'(NUM_OPS - 1)) state_d = S_DONE;
      else                              idx_d   = idx_d + IDX_W'(1);
    end

    busy_d  = (state_d == S_ENTRY);
    done_d  = (state_d == S_DONE);
    op_en_d = busy_d ? (NUM_OPS'(1) << idx_d) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the operand store is only NUM_OPS words of flops, and reset must
  // discard committed data, so it is reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      ops_q      <= '0;
      op_en_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= bus.key_valid;
      armed_q    <= armed_q | ~bus.key_valid;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ops_q      <= ops_d;
      op_en_q    <= op_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.operands    = ops_q;
  assign bus.op_enable   = op_en_q;
  assign bus.entry_value = acc_q;
  assign bus.digit_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.done_valid  = done_q;
endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry at default parameters; each scenario
// task compares the full output vector against hand-computed values.
module tb_keypad_operand_entry;
  localparam int NUM_OPS = 2;
  localparam int DIGITS  = 3;
  localparam int WIDTH   = 10;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  keypad_operand_entry_if #(.NUM_OPS(NUM_OPS), .DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  keypad_operand_entry #(.NUM_OPS(NUM_OPS), .DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // {operand1, operand0, op_enable, entry_value, digit_count, busy, done_valid}
  function automatic logic [35:0] snap();
    return {bus.operands, bus.op_enable, bus.entry_value, bus.digit_count,
            bus.busy, bus.done_valid};
  endfunction

  function automatic logic [35:0] exp_vec(input logic [9:0] o1, input logic [9:0] o0,
                                          input logic [1:0] en, input logic [9:0] ev,
                                          input logic [1:0] dc, input logic b,
                                          input logic dv);
    return {o1, o0, en, ev, dc, b, dv};
  endfunction

  task automatic press(input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.done_ack = 1'b1;
    @(negedge clk);
    bus.done_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (snap() !== exp_vec(0, 0, 2'b00, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", snap(), exp_vec(0, 0, 2'b00, 0, 0, 0, 0));
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [35:0] e;
    press(4'd1);
    e = exp_vec(0, 0, 2'b01, 1, 1, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL basic_first_digit got=%h exp=%h", snap(), e); end
    press(4'd2);
    press(4'd3);
    e = exp_vec(0, 123, 2'b10, 0, 0, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL basic_autocommit0 got=%h exp=%h", snap(), e); end
    press(4'd4);
    press(4'd5);
    e = exp_vec(0, 123, 2'b10, 45, 2, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL basic_partial1 got=%h exp=%h", snap(), e); end
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd6;
    #1;
    checks++; if (snap() !== e) begin failures++; $display("FAIL basic_before_edge got=%h exp=%h", snap(), e); end
    @(negedge clk);
    e = exp_vec(456, 123, 2'b00, 0, 0, 0, 1);
    checks++; if (snap() !== e) begin failures++; $display("FAIL basic_done_latency got=%h exp=%h", snap(), e); end
    bus.key_valid = 1'b0;
    @(negedge clk);
    press(4'd7);
    press(4'hA);
    checks++; if (snap() !== e) begin failures++; $display("FAIL done_keys_ignored got=%h exp=%h", snap(), e); end
    @(negedge clk);
    bus.done_ack  = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd1;
    @(negedge clk);
    bus.done_ack  = 1'b0;
    bus.key_valid = 1'b0;
    e = exp_vec(456, 123, 2'b00, 0, 0, 0, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL ack_with_key got=%h exp=%h", snap(), e); end
    repeat (2) @(negedge clk);
    checks++; if (snap() !== e) begin failures++; $display("FAIL ack_key_discarded got=%h exp=%h", snap(), e); end
  endtask

  task automatic test_enter_ignored();
    logic [35:0] e;
    press(4'd7);
    e = exp_vec(0, 0, 2'b01, 7, 1, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL idle_digit_clears got=%h exp=%h", snap(), e); end
    press(4'hA);
    e = exp_vec(0, 7, 2'b10, 0, 0, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL enter_commit got=%h exp=%h", snap(), e); end
    press(4'hA);
    checks++; if (snap() !== e) begin failures++; $display("FAIL enter_empty_ignored got=%h exp=%h", snap(), e); end
    press(4'd9);
    press(4'd9);
    press(4'd9);
    e = exp_vec(999, 7, 2'b00, 0, 0, 0, 1);
    checks++; if (snap() !== e) begin failures++; $display("FAIL max_operand_done got=%h exp=%h", snap(), e); end
    ack_pulse();
    e = exp_vec(999, 7, 2'b00, 0, 0, 0, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL ack_retains got=%h exp=%h", snap(), e); end
  endtask

  task automatic test_hold();
    logic [35:0] e;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    repeat (5) @(negedge clk);
    bus.key_valid = 1'b0;
    e = exp_vec(0, 0, 2'b01, 5, 1, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL hold_single_event got=%h exp=%h", snap(), e); end
    press(4'd0);
    e = exp_vec(0, 0, 2'b01, 50, 2, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL hold_then_zero got=%h exp=%h", snap(), e); end
    ack_pulse();
    @(negedge clk);
    checks++; if (snap() !== e) begin failures++; $display("FAIL ack_outside_done got=%h exp=%h", snap(), e); end
    press(4'hF);
  endtask

  task automatic test_clear();
    logic [35:0] e;
    press(4'hB);
    press(4'hC);
    e = exp_vec(0, 0, 2'b00, 0, 0, 0, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL idle_nondigit_ignored got=%h exp=%h", snap(), e); end
    press(4'd1);
    press(4'd2);
    press(4'hC);
    e = exp_vec(0, 0, 2'b01, 0, 0, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL clear_entry got=%h exp=%h", snap(), e); end
    press(4'hB);
    checks++; if (snap() !== e) begin failures++; $display("FAIL code_b_ignored got=%h exp=%h", snap(), e); end
    press(4'd3);
    press(4'hA);
    e = exp_vec(0, 3, 2'b10, 0, 0, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL clear_then_commit got=%h exp=%h", snap(), e); end
    press(4'hF);
  endtask

  task automatic test_abort();
    logic [35:0] e;
    press(4'd4);
    press(4'hA);
    press(4'd8);
    e = exp_vec(0, 4, 2'b10, 8, 1, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL abort_setup got=%h exp=%h", snap(), e); end
    press(4'hF);
    e = exp_vec(0, 0, 2'b00, 0, 0, 0, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL abort_zeroes got=%h exp=%h", snap(), e); end
  endtask

  task automatic test_rst_mid();
    logic [35:0] e;
    press(4'd1);
    press(4'hA);
    press(4'd5);
    e = exp_vec(0, 1, 2'b10, 5, 1, 1, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL rst_setup got=%h exp=%h", snap(), e); end
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd7;
    #2 rst = 1'b1;
    #1;
    e = exp_vec(0, 0, 2'b00, 0, 0, 0, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL rst_async got=%h exp=%h", snap(), e); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (snap() !== e) begin failures++; $display("FAIL rst_held_key_ignored got=%h exp=%h", snap(), e); end
    bus.key_valid = 1'b0;
    press(4'd2);
    press(4'hA);
    press(4'd3);
    press(4'hA);
    e = exp_vec(3, 2, 2'b00, 0, 0, 0, 1);
    checks++; if (snap() !== e) begin failures++; $display("FAIL rst_new_sequence got=%h exp=%h", snap(), e); end
    ack_pulse();
    e = exp_vec(3, 2, 2'b00, 0, 0, 0, 0);
    checks++; if (snap() !== e) begin failures++; $display("FAIL rst_final_ack got=%h exp=%h", snap(), e); end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.done_ack  = 1'b0;
    test_reset();
    test_basic();
    test_enter_ignored();
    test_hold();
    test_clear();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_operand_entry.md
KEYPAD_OPERAND_ENTRY -- requirements
Module: keypad_operand_entry

Interface
REQ-001 SHALL have parameter NUM_OPS, default 2: number of operands collected per transaction (2..8).
REQ-002 SHALL have parameter DIGITS, default 3: maximum decimal digits per operand (1..4).
REQ-003 SHALL have parameter WIDTH, default 10: bits per operand; legal only if 10^DIGITS-1 < 2^WIDTH.
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port key_valid  input  1  key strobe, level; only its rising edge is a key event.
REQ-007 SHALL have port key_code  input  4  0x0-0x9 digit, 0xA ENTER, 0xC CLEAR, 0xF ABORT; other codes ignored.
REQ-008 SHALL have port done_ack  input  1  consumer accepts completed operand set.
REQ-009 SHALL have port operands  output  NUM_OPS*WIDTH  committed operands, operand k in bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port op_enable  output  NUM_OPS  one-hot operand currently being entered; zero outside ENTRY.
REQ-011 SHALL have port entry_value  output  WIDTH  running accumulator of current operand, for display.
REQ-012 SHALL have port digit_count  output  clog2(DIGITS+1)  digits accepted into current operand.
REQ-013 SHALL have port busy  output  1  high in ENTRY.
REQ-014 SHALL have port done_valid  output  1  high in DONE; operands stable and valid.

Function
REQ-015 Key event SHALL be key_valid high with key_valid registered low the previous cycle; key_code sampled that same cycle; holding key_valid SHALL produce one event.
REQ-016 FSM SHALL have states IDLE, ENTRY, DONE; all outputs registered, updated the cycle after the event edge.
REQ-017 IDLE: digit event SHALL clear all operands, select operand 0, load accumulator = digit, digit_count = 1, go ENTRY; ENTER/CLEAR/ABORT/other ignored.
REQ-018 ENTRY digit with digit_count < DIGITS SHALL set accumulator = accumulator*10 + digit (WIDTH bits, no overflow by REQ-003), digit_count +1.
REQ-019 When a digit makes digit_count equal DIGITS, operand SHALL auto-commit in that same update.
REQ-020 ENTRY ENTER with digit_count >= 1 SHALL commit; ENTER with digit_count = 0 SHALL be ignored.
REQ-021 Commit SHALL write accumulator to operand[op_idx], clear accumulator and digit_count; if op_idx = NUM_OPS-1 go DONE, else op_idx +1 and stay ENTRY.
REQ-022 ENTRY CLEAR SHALL zero accumulator and digit_count; op_idx and committed operands unchanged.
REQ-023 ENTRY ABORT SHALL zero all operands, accumulator, digit_count, op_idx and go IDLE.
REQ-024 DONE: all key events ignored; done_valid held until done_ack; done_ack SHALL go IDLE next cycle with operands retained.
REQ-025 done_ack outside DONE SHALL be ignored; done_ack and key event in the same DONE cycle: ack taken, key discarded.
REQ-026 Latency: final commit event cycle N -> done_valid high at cycle N+1.

Reset
REQ-027 rst high SHALL immediately force IDLE; operands, entry_value, digit_count, op_idx, op_enable, busy, done_valid = 0; key_valid edge register = 0.
REQ-028 rst mid-entry or in DONE SHALL discard all partial and committed data; first key after release with key_valid already high SHALL NOT count as an event.

Verification (defaults NUM_OPS=2, DIGITS=3, WIDTH=10)
REQ-029 Keys 1,2,3,4,5,6 -> operand0=123 after '3', op_enable 01->10, operand1=456, done_valid one cycle after '6'; done_ack -> IDLE, operands kept.
REQ-030 Keys 7,ENTER,ENTER,9,9,9 -> operand0=7, second ENTER ignored, operand1=999, done_valid=1.
REQ-031 key_valid held high 5 cycles with code 5, then released, then code 0 -> one '5' then '0', entry_value=50, digit_count=2.
REQ-032 Keys 1,2,CLEAR,3,ENTER -> operand0=3, digit_count 0, op_enable=10; code 0xB ignored anywhere.
REQ-033 Keys 4,ENTER,8,ABORT -> all zero, IDLE, busy=0; keys in DONE with no ack -> operands unchanged.
REQ-034 rst pulsed mid-operand1 -> all outputs 0 asynchronously, before next clk edge; new sequence 2,ENTER,3,ENTER -> operands 2,3.
